// File: rtl/floatdata_input_fifo_if.sv
// Bus bundle between the float read-back FIFO and its two masters:
// the Nios II Avalon-MM port and the accelerator's valid/ready stream.
interface floatdata_input_fifo_if #(
    parameter int DATA_WIDTH = 32
);
    logic [1:0]            address;
    logic                  chipselect;
    logic                  read_n;
    logic                  write_n;
    logic [DATA_WIDTH-1:0] writedata;
    logic [DATA_WIDTH-1:0] readdata;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  irq;

    modport slave (
        input  address, chipselect, read_n, write_n, writedata, in_data, in_valid,
        output readdata, in_ready, irq
    );

    modport master (
        output address, chipselect, read_n, write_n, writedata, in_data, in_valid,
        input  readdata, in_ready, irq
    );
endinterface

// File: rtl/floatdata_input_fifo.sv
// Float result read-back FIFO: accelerator pushes over a stream, Nios II pops
// first-word-fall-through words from address 0 and polls status / takes irq.
module floatdata_input_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    floatdata_input_fifo_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2-1:0] wr_addr;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  underflow_q, underflow_d;
    logic [1:0]            irq_mask_q, irq_mask_d;
    logic [DATA_WIDTH-1:0] rdata;

    logic empty, full, push, pop, rd_access, wr_access, flush, clr_uf;
    logic unused_wdata;

    assign empty     = (count_q == '0);
    assign full      = (count_q == (DEPTH_LOG2+1)'(DEPTH));
    assign push      = bus.in_valid & bus.in_ready;
    assign rd_access = bus.chipselect & ~bus.read_n & (bus.address == 2'd0);
    assign wr_access = bus.chipselect & ~bus.write_n;
    assign flush     = wr_access & (bus.address == 2'd3) & bus.writedata[0];
    assign clr_uf    = wr_access & (bus.address == 2'd3) & bus.writedata[1];
    assign pop       = rd_access & ~empty & ~flush;
    // A push coinciding with flush lands in slot 0 so no stream word is lost
    assign wr_addr   = flush ? '0 : wr_ptr_q;

    assign bus.in_ready = ~full & reset_n;
    assign bus.irq      = (irq_mask_q[0] & ~empty) | (irq_mask_q[1] & underflow_q);
    assign bus.readdata = rdata;
    assign unused_wdata = ^bus.writedata[DATA_WIDTH-1:2];

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        underflow_d = underflow_q;
        irq_mask_d  = irq_mask_q;

        if (flush) begin
            wr_ptr_d = DEPTH_LOG2'(push);
            rd_ptr_d = '0;
            count_d  = (DEPTH_LOG2+1)'(push);
        end else begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(push);
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(pop);
            count_d  = count_q + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
        end

        // Set has priority over a same-cycle clear
        if (rd_access && empty) begin
            underflow_d = 1'b1;
        end else if (clr_uf) begin
            underflow_d = 1'b0;
        end

        if (wr_access && (bus.address == 2'd2)) begin
            irq_mask_d = bus.writedata[1:0];
        end
    end

    always_comb begin
        rdata = '0;
        case (bus.address)
            2'd0: if (!empty) rdata = mem_q[rd_ptr_q];
            2'd1: begin
                rdata[DEPTH_LOG2:0] = count_q;
                rdata[16]           = empty;
                rdata[17]           = full;
                rdata[18]           = underflow_q;
            end
            2'd2:    rdata[1:0] = irq_mask_q;
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
            irq_mask_q  <= 2'b00;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
            irq_mask_q  <= irq_mask_d;
        end
    end

    // Storage is deliberately left out of reset; push is already gated by reset_n
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_addr] <= bus.in_data;
        end
    end
endmodule

// File: tb/tb_floatdata_input_fifo.sv
// Bench for floatdata_input_fifo: directed steps plus random traffic, checked
// every cycle against a queue-based model of the FIFO and its register map.
module tb_floatdata_input_fifo;
    logic clk = 1'b0;
    logic reset_n;

    floatdata_input_fifo_if bus ();

    floatdata_input_fifo dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] q[$];
    logic        uf_m;
    logic [1:0]  mask_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] exp_rdata();
        logic [31:0] s;
        s = '0;
        case (bus.address)
            2'd0: s = (q.size() != 0) ? q[0] : 32'h0;
            2'd1: begin
                s = 32'(q.size());
                s[16] = (q.size() == 0);
                s[17] = (q.size() == 16);
                s[18] = uf_m;
            end
            2'd2: s = {30'b0, mask_m};
            default: s = '0;
        endcase
        return s;
    endfunction

    // Inputs are set at posedge+1; checks at posedge+2; model advances at posedge.
    task automatic step(input bit has_exp = 0, input logic [31:0] exp_c = 0, input string tag = "");
        bit          pushm, rdacc, wracc, fl, was_empty;
        #1;
        if (has_exp) check(tag, bus.readdata, exp_c);
        check("readdata_model", bus.readdata, exp_rdata());
        check("in_ready_model", 32'(bus.in_ready), 32'(reset_n && q.size() < 16));
        check("irq_model", 32'(bus.irq),
              32'((mask_m[0] && q.size() != 0) || (mask_m[1] && uf_m)));
        @(posedge clk);
        if (!reset_n) begin
            q.delete();
            uf_m   = 1'b0;
            mask_m = 2'b00;
        end else begin
            pushm     = bus.in_valid && (q.size() < 16);
            rdacc     = bus.chipselect && !bus.read_n && (bus.address == 2'd0);
            wracc     = bus.chipselect && !bus.write_n;
            fl        = wracc && (bus.address == 2'd3) && bus.writedata[0];
            was_empty = (q.size() == 0);
            if (fl) q.delete();
            else if (rdacc && !was_empty) void'(q.pop_front());
            if (pushm) q.push_back(bus.in_data);
            if (rdacc && was_empty) uf_m = 1'b1;
            else if (wracc && bus.address == 2'd3 && bus.writedata[1]) uf_m = 1'b0;
            if (wracc && bus.address == 2'd2) mask_m = bus.writedata[1:0];
        end
        #1;
    endtask

    task automatic idle_bus();
        bus.chipselect = 1'b0;
        bus.read_n     = 1'b1;
        bus.write_n    = 1'b1;
        bus.address    = 2'd0;
        bus.writedata  = '0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
    endtask

    task automatic rd(input logic [1:0] a, input bit has, input logic [31:0] e, input string tag);
        bus.chipselect = 1'b1;
        bus.read_n     = 1'b0;
        bus.address    = a;
        step(has, e, tag);
        bus.chipselect = 1'b0;
        bus.read_n     = 1'b1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = a;
        bus.writedata  = d;
        step();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 2'd0;
    endtask

    task automatic push_word(input logic [31:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int op;
        idle_bus();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        q.delete();
        uf_m   = 1'b0;
        mask_m = 2'b00;
        step();
        reset_n = 1'b1;
        step();

        // Reset then idle
        check("in_ready_after_reset", 32'(bus.in_ready), 32'd1);
        check("irq_after_reset", 32'(bus.irq), 32'd0);
        rd(2'd1, 1, 32'h0001_0000, "status_empty");
        rd(2'd0, 1, 32'h0, "read_empty");
        rd(2'd1, 1, 32'h0005_0000, "status_underflow");
        wr(2'd3, 32'h2);

        // Three float words in order
        push_word(32'h3F80_0000);
        push_word(32'h4000_0000);
        push_word(32'hC049_0FDB);
        rd(2'd1, 1, 32'h0000_0003, "status_count3");
        rd(2'd0, 1, 32'h3F80_0000, "pop_1p0");
        rd(2'd0, 1, 32'h4000_0000, "pop_2p0");
        rd(2'd0, 1, 32'hC049_0FDB, "pop_mpi");
        rd(2'd1, 1, 32'h0001_0000, "status_empty_again");

        // Fill to full, hold a 17th word, pop one, accept it, drain with wrap
        for (int i = 0; i < 16; i++) push_word(32'(i));
        rd(2'd1, 1, 32'h0002_0010, "status_full");
        check("in_ready_full", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h1234_5678;
        step();
        step();
        rd(2'd0, 1, 32'h0, "pop_from_full");
        check("in_ready_after_pop", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        for (int i = 1; i < 16; i++) rd(2'd0, 1, 32'(i), "drain_word");
        rd(2'd0, 1, 32'h1234_5678, "drain_held");
        rd(2'd1, 1, 32'h0001_0000, "status_drained");

        // Non-empty interrupt
        wr(2'd2, 32'h1);
        check("irq_mask1_empty", 32'(bus.irq), 32'd0);
        push_word($urandom);
        check("irq_after_push", 32'(bus.irq), 32'd1);
        rd(2'd0, 0, 32'h0, "");
        check("irq_after_last_pop", 32'(bus.irq), 32'd0);

        // Underflow interrupt
        wr(2'd2, 32'h2);
        rd(2'd0, 1, 32'h0, "underflow_read");
        check("irq_underflow", 32'(bus.irq), 32'd1);
        wr(2'd3, 32'h2);
        check("irq_underflow_cleared", 32'(bus.irq), 32'd0);
        rd(2'd1, 1, 32'h0001_0000, "status_uf_cleared");
        rd(2'd2, 1, 32'h0000_0002, "irq_mask_readback");
        wr(2'd2, 32'h0);

        // Flush together with a push
        for (int i = 0; i < 5; i++) push_word($urandom);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = 2'd3;
        bus.writedata  = 32'h1;
        bus.in_valid   = 1'b1;
        bus.in_data    = 32'hDEAD_BEEF;
        step();
        idle_bus();
        rd(2'd1, 1, 32'h0000_0001, "status_after_flush");
        rd(2'd0, 1, 32'hDEAD_BEEF, "pop_after_flush");

        // Push and pop in the same cycle with four queued
        for (int i = 0; i < 4; i++) push_word($urandom);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hA5A5_0004;
        rd(2'd0, 0, 32'h0, "");
        bus.in_valid = 1'b0;
        rd(2'd1, 1, 32'h0000_0004, "status_push_pop");
        for (int i = 0; i < 3; i++) rd(2'd0, 0, 32'h0, "");
        rd(2'd0, 1, 32'hA5A5_0004, "push_pop_order");

        // Push into an empty FIFO while reading it: no bypass
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h0BAD_F00D;
        rd(2'd0, 1, 32'h0, "push_read_empty");
        bus.in_valid = 1'b0;
        rd(2'd1, 1, 32'h0004_0001, "status_push_read_empty");
        wr(2'd3, 32'h2);
        rd(2'd0, 1, 32'h0BAD_F00D, "pop_after_no_bypass");

        // Random traffic, with one reset in the middle
        for (int i = 0; i < 400; i++) begin
            idle_bus_keep_stream();
            reset_n = (i != 200);
            op = $urandom_range(0, 11);
            case (op)
                0, 1, 2, 3: begin bus.chipselect = 1'b1; bus.read_n = 1'b0; bus.address = 2'd0; end
                4: begin bus.chipselect = 1'b1; bus.read_n = 1'b0; bus.address = 2'd1; end
                5: begin bus.chipselect = 1'b1; bus.read_n = 1'b0; bus.address = 2'd2; end
                6: begin
                    bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = 2'd2;
                    bus.writedata = $urandom;
                end
                7: begin
                    bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = 2'd3;
                    bus.writedata = {30'b0, 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1))};
                end
                8: begin bus.chipselect = 1'b0; bus.read_n = 1'b0; bus.address = 2'($urandom); end
                default: ;
            endcase
            step();
        end
        reset_n = 1'b1;
        idle_bus();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Stream side keeps a blocked word stable until it is accepted
    task automatic idle_bus_keep_stream();
        bus.chipselect = 1'b0;
        bus.read_n     = 1'b1;
        bus.write_n    = 1'b1;
        bus.address    = 2'd0;
        bus.writedata  = '0;
        if (!(bus.in_valid && q.size() >= 16)) begin
            bus.in_valid = 1'($urandom_range(0, 2) != 0);
            bus.in_data  = $urandom;
        end
    endtask
endmodule
